// File: rtl/sar_result_reader.sv
// Periodic SAR conversion reader: cnvst/eoc handshake feeding a show-ahead FIFO with a valid/ready output.
// Optional WAIT-state timeout is compiled in when SAR_RD_TIMEOUT_EN is defined.
module sar_result_reader #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PERIOD     = 32,
  parameter int TIMEOUT    = 40
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  output logic                        cnvst,
  input  logic                        eoc,
  input  logic [DATA_W-1:0]           sar,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        timeout_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PERIOD);
  localparam logic [PW-1:0] PER_LOAD = PW'(PERIOD - 1);
  localparam logic [PW-1:0] PER_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     per_q, per_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              wr_req, rd, full, wr_ok;

`ifdef SAR_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WCNT_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wcnt_q;
  logic          tmo_q, tmo_hit;
`endif

  // Sequencer: the period counter reaches zero on the edge that enters START,
  // so an IDLE cycle with the counter at one or zero keeps pulses PERIOD apart.
  always_comb begin
    state_d = state_q;
    per_d   = (per_q != '0) ? per_q - PER_ONE : per_q;
    cnvst   = 1'b0;
    wr_req  = 1'b0;
`ifdef SAR_RD_TIMEOUT_EN
    tmo_hit = 1'b0;
`endif
    case (state_q)
      IDLE: if (en && per_q <= PER_ONE) state_d = START;
      START: begin
        cnvst   = 1'b1;
        per_d   = PER_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (eoc) begin
          wr_req  = 1'b1;
          state_d = IDLE;
        end
`ifdef SAR_RD_TIMEOUT_EN
        else if (wcnt_q == WCNT_LAST) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO: a write into a full FIFO is kept only when the head leaves the same cycle.
  always_comb begin
    m_valid = (cnt_q != '0);
    rd      = m_valid & m_ready;
    full    = (cnt_q == CNT_FULL);
    wr_ok   = wr_req & (~full | rd);
    ovf_d   = ovf_q | (wr_req & full & ~rd);
    case ({wr_ok, rd})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      per_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd)    rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= sar;
  end

`ifdef SAR_RD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wcnt_q <= (state_q == WAIT) ? wcnt_q + TW'(1) : '0;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_sar_result_reader.sv
// Scoreboard bench for sar_result_reader: SAR responder, cycle-level reference model, decoupled monitor.
module tb_sar_result_reader;
  localparam int DW = 8, DEPTH = 4, PER = 32, TMO = 40;

  logic          clk = 1'b0;
  logic          rst, en, eoc, m_ready, cnvst, m_valid, overflow, timeout_err;
  logic [DW-1:0] sar, m_data;
  logic [2:0]    fifo_count;

  always #5 clk = ~clk;

  sar_result_reader #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .PERIOD(PER), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .cnvst(cnvst), .eoc(eoc), .sar(sar),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .overflow(overflow), .timeout_err(timeout_err)
  );

  int total = 0, bad = 0;

  // Reference model state: cycle index since reset, FIFO occupancy and contents,
  // and the earliest cycle the next conversion may start.
  int            cyc = 0, mcount = 0, last_st = -1000, earliest = 1;
  bit            armed = 0, outstanding = 0, exp_cnvst = 0, m_ovf = 0, m_tmo = 0;
  logic [DW-1:0] exp_q[$];
  int            st_log[$];
  logic [DW-1:0] rd_log[$];

  // Stimulus knobs
  bit            resp_on = 1, pend = 0;
  int            eoc_at = 0, lat_lo = 18, lat_hi = 18, rdy_mode = 0, stray_pct = 0;
  bit            rdy_val = 1;
  logic [DW-1:0] codes[$];

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      armed = 1; cyc = 0; mcount = 0; exp_q.delete(); m_ovf = 0; m_tmo = 0;
      outstanding = 0; earliest = 1; last_st = -1000; exp_cnvst = 0;
    end else if (armed) begin
      bit rdm;
      rdm = m_ready && (mcount > 0);
      if (eoc && outstanding) begin
        outstanding = 0;
        earliest = imax(last_st + PER, cyc + 2);
        if (mcount < DEPTH || rdm) begin
          exp_q.push_back(sar);
          if (!rdm) mcount++;
        end else m_ovf = 1;
      end else if (rdm) mcount--;
      if (exp_cnvst) begin
        outstanding = 1;
        last_st = cyc;
      end
`ifdef SAR_RD_TIMEOUT_EN
      else if (outstanding && cyc == last_st + TMO) begin
        m_tmo = 1;
        outstanding = 0;
        earliest = imax(last_st + PER, cyc + 2);
      end
`endif
      cyc++;
      exp_cnvst = !outstanding && en && (cyc >= earliest);
    end
  end

  always @(negedge clk) begin
    if (armed && !rst) begin
      chk("cnvst", cnvst, exp_cnvst);
      chk("fifo_count", fifo_count, mcount);
      chk("m_valid", m_valid, mcount > 0);
      chk("overflow", overflow, m_ovf);
      chk("timeout_err", timeout_err, m_tmo);
      if (!m_valid) chk("m_data_empty", m_data, 0);
      if (m_valid && exp_q.size() > 0) begin
        chk("m_data", m_data, exp_q[0]);
        if (m_ready) begin
          rd_log.push_back(m_data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    eoc = 1'b0;
    sar = DW'($urandom);
    if (pend && cyc == eoc_at) begin
      eoc  = 1'b1;
      sar  = (codes.size() > 0) ? codes.pop_front() : DW'($urandom);
      pend = 0;
    end else if (!pend && !cnvst && stray_pct > 0 && $urandom_range(99) < stray_pct) begin
      eoc = 1'b1;
    end
    if (cnvst) begin
      st_log.push_back(cyc);
      if (resp_on) begin
        pend   = 1;
        eoc_at = cyc + $urandom_range(lat_hi, lat_lo);
      end
    end
    case (rdy_mode)
      0:       m_ready = rdy_val;
      1:       m_ready = 1'($urandom_range(1));
      default: m_ready = eoc;
    endcase
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; eoc = 1'b0; pend = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    st_log.delete();
    rd_log.delete();
  endtask

  task automatic wait_starts(int k, int lim);
    int n = 0;
    while (st_log.size() < k && n < lim) begin
      step();
      n++;
    end
    if (st_log.size() < k) begin
      total++; bad++;
      $display("FAIL wait_cnvst: saw %0d pulses, required %0d within %0d cycles", st_log.size(), k, lim);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; eoc = 1'b0; sar = '0; m_ready = 1'b0;

    // 1: periodic conversions at fixed latency, consumer always ready
    en = 1'b1; rdy_mode = 0; rdy_val = 1;
    codes = '{8'hA5, 8'hA5, 8'hA5};
    do_reset();
    run(80);
    wait_starts(3, 40);
    chk("t1_cnvst0", st_log[0], 1);
    chk("t1_cnvst1", st_log[1], 33);
    chk("t1_cnvst2", st_log[2], 65);
    chk("t1_data", rd_log[0], 8'hA5);

    // 2: consumer stalled, five conversions into a 4-deep FIFO
    rdy_val = 0; codes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    do_reset();
    wait_starts(5, 200);
    en = 1'b0;
    run(30);
    chk("t2_count", fifo_count, 4);
    chk("t2_overflow", overflow, 1);
    rdy_val = 1;
    run(8);
    chk("t2_nreads", rd_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_order", rd_log[i], i + 1);

    // 3: full FIFO, eoc coincides with a read
    en = 1'b1; rdy_val = 0; codes = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    do_reset();
    wait_starts(5, 200);
    en = 1'b0; rdy_mode = 2;
    run(30);
    chk("t3_count", fifo_count, 4);
    chk("t3_overflow", overflow, 0);
    rdy_mode = 0; rdy_val = 1; rd_log.delete();
    run(8);
    for (int i = 0; i < 4; i++) chk("t3_order", rd_log[i], 8'h12 + i);

    // 4: en dropped five cycles into a conversion
    en = 1'b1;
    do_reset();
    wait_starts(1, 10);
    run(5);
    en = 1'b0;
    run(80);
    chk("t4_starts", st_log.size(), 1);
    chk("t4_reads", rd_log.size(), 1);

    // 5: reset in the middle of WAIT
    en = 1'b1; rdy_val = 0;
    do_reset();
    wait_starts(1, 10);
    run(10);
    do_reset();
    @(negedge clk);
    chk("t5_cnvst", cnvst, 0);
    chk("t5_count", fifo_count, 0);
    chk("t5_valid", m_valid, 0);
    run(40);
    chk("t5_count_after", fifo_count, 1);

    // 6: eoc never arrives
    resp_on = 0; rdy_val = 1;
    do_reset();
    run(100);
`ifdef SAR_RD_TIMEOUT_EN
    chk("t6_starts", st_log.size(), 3);
    chk("t6_timeout_err", timeout_err, 1);
`else
    chk("t6_starts", st_log.size(), 1);
    chk("t6_timeout_err", timeout_err, 0);
`endif
    chk("t6_count", fifo_count, 0);

    // 7: randomized latency, codes, back-pressure, en and stray eoc
    resp_on = 1; lat_lo = 2; lat_hi = 36; rdy_mode = 1; stray_pct = 5; en = 1'b1;
    codes.delete();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step();
      if ($urandom_range(99) == 0) en = ~en;
      if (i == 1000) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
